memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memoryArbiter

---
 rtl/memory_arbiter.sv | 117 +++++++++++
 tb/tb_memory_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one 64-bit backing-memory port between an
// instruction-refill port and a 32-bit data port; one access in flight at a time.
module memory_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iReq,
    input  logic [31:0] iAddress,
    output logic        iValid,
    output logic [63:0] iData,
    input  logic        dReq,
    input  logic        dWrite,
    input  logic [31:0] dAddress,
    input  logic [31:0] dWriteData,
    input  logic [3:0]  dByteEnable,
    output logic        dValid,
    output logic [31:0] dReadData,
    output logic        memRequest,
    output logic        memWrite,
    output logic [31:0] memAddress,
    output logic [63:0] memWriteData,
    output logic [7:0]  memByteEnable,
    input  logic        memReady,
    input  logic [63:0] memReadData,
    output logic        grantData,
    output logic        timeoutError
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} stateType;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    stateType    state, nextState;
    logic        lastData;
    logic        grantSel;
    logic        writeLatch;
    logic        dHigh;
    logic [7:0]  waitCount;
    logic [63:0] lineBuf;
    logic        pickData;
    logic        timeoutHit;
    logic        unusedAddrBits;

    assign unusedAddrBits = ^{iAddress[2:0], dAddress[1:0]};

    // Data wins outright, or on a tie when instruction was granted last.
    assign pickData   = dReq && (!iReq || !lastData);
    assign timeoutHit = (state == ISSUE) && !memReady && (waitCount == TIMEOUT_LAST);

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (iReq || dReq) nextState = ISSUE;
            ISSUE:   if (memReady || timeoutHit) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            lastData      <= 1'b0;
            grantSel      <= 1'b0;
            writeLatch    <= 1'b0;
            dHigh         <= 1'b0;
            waitCount     <= '0;
            lineBuf       <= '0;
            memAddress    <= '0;
            memWriteData  <= '0;
            memByteEnable <= '0;
            timeoutError  <= 1'b0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: if (iReq || dReq) begin
                    grantSel  <= pickData;
                    waitCount <= '0;
                    if (pickData) begin
                        memAddress    <= {dAddress[31:3], 3'b000};
                        writeLatch    <= dWrite;
                        memWriteData  <= {dWriteData, dWriteData};
                        memByteEnable <= dAddress[2] ? {dByteEnable, 4'b0} : {4'b0, dByteEnable};
                        dHigh         <= dAddress[2];
                    end else begin
                        memAddress    <= {iAddress[31:3], 3'b000};
                        writeLatch    <= 1'b0;
                        memWriteData  <= '0;
                        memByteEnable <= '0;
                        dHigh         <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (memReady) begin
                        lineBuf <= memReadData;
                    end else if (timeoutHit) begin
                        lineBuf      <= '0;
                        timeoutError <= 1'b1;
                    end else begin
                        waitCount <= waitCount + 8'd1;
                    end
                end
                DONE:    lastData <= grantSel;
                default: ;
            endcase
        end
    end

    assign memRequest = (state == ISSUE);
    assign memWrite   = (state == ISSUE) && writeLatch;
    assign iValid     = (state == DONE) && !grantSel;
    assign dValid     = (state == DONE) && grantSel;
    assign grantData  = grantSel;
    assign iData      = lineBuf;
    // Stores return zero; loads pick the word addressed by bit 2.
    assign dReadData  = writeLatch ? 32'h0 : (dHigh ? lineBuf[63:32] : lineBuf[31:0]);
endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: vector table with a scoreboard plus
// hand sequences for tie order, slow memory, watchdog abort and mid-access reset.
module tb_memory_arbiter;
    logic        clk, reset;
    logic        iReq, iValid, dReq, dWrite, dValid;
    logic [31:0] iAddress, dAddress, dWriteData, dReadData, memAddress;
    logic [63:0] iData, memWriteData, memReadData;
    logic [3:0]  dByteEnable;
    logic [7:0]  memByteEnable;
    logic        memRequest, memWrite, memReady, grantData, timeoutError;

    memory_arbiter #(.TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .reset(reset),
        .iReq(iReq), .iAddress(iAddress), .iValid(iValid), .iData(iData),
        .dReq(dReq), .dWrite(dWrite), .dAddress(dAddress), .dWriteData(dWriteData),
        .dByteEnable(dByteEnable), .dValid(dValid), .dReadData(dReadData),
        .memRequest(memRequest), .memWrite(memWrite), .memAddress(memAddress),
        .memWriteData(memWriteData), .memByteEnable(memByteEnable),
        .memReady(memReady), .memReadData(memReadData),
        .grantData(grantData), .timeoutError(timeoutError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        isData;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [63:0] memData;
        logic [31:0] expAddr;
        logic [7:0]  expBe;
        logic [63:0] expVal;
    } vecT;

    typedef struct {
        logic        isData;
        logic [63:0] data;
    } expT;

    expT sb[$];
    vecT vecs[7];
    int  nVec = 0;
    int  nErr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic runVec(input vecT v, input int idx);
        expT e;
        bit  seen;
        @(negedge clk);
        iReq = !v.isData; dReq = v.isData;
        iAddress = v.addr; dAddress = v.addr;
        dWrite = v.wr; dWriteData = v.wdata; dByteEnable = v.be;
        memReady = 1'b1; memReadData = v.memData;
        e.isData = v.isData; e.data = v.expVal;
        sb.push_back(e);
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (memRequest) seen = 1'b1;
        end
        chk($sformatf("v%0d memRequest", idx), 64'(seen), 64'd1);
        if (seen) begin
            chk($sformatf("v%0d memAddress", idx), 64'(memAddress), 64'(v.expAddr));
            chk($sformatf("v%0d memByteEnable", idx), 64'(memByteEnable), 64'(v.expBe));
            chk($sformatf("v%0d memWrite", idx), 64'(memWrite), 64'(v.isData & v.wr));
            chk($sformatf("v%0d grantData", idx), 64'(grantData), 64'(v.isData));
            if (v.isData) chk($sformatf("v%0d memWriteData", idx), memWriteData, {v.wdata, v.wdata});
        end
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (iValid || dValid) seen = 1'b1;
        end
        chk($sformatf("v%0d validPulse", idx), 64'(seen), 64'd1);
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("v%0d validPort", idx), 64'({dValid, iValid}), e.isData ? 64'd2 : 64'd1);
            chk($sformatf("v%0d validData", idx), e.isData ? 64'(dReadData) : iData, e.data);
        end
        iReq = 1'b0; dReq = 1'b0;
    endtask

    // Both ports request together; data must finish at cycle 2, instruction at 5.
    task automatic tieTest(input string tag);
        int dCyc, iCyc, nPulse;
        @(negedge clk);
        iReq = 1'b1; dReq = 1'b1; iAddress = 32'h80; dAddress = 32'h300;
        dWrite = 1'b0; dByteEnable = 4'h0; memReady = 1'b1;
        memReadData = 64'h0123_4567_89AB_CDEF;
        dCyc = -1; iCyc = -1; nPulse = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (dValid) begin if (dCyc < 0) dCyc = c; nPulse++; dReq = 1'b0; end
            if (iValid) begin if (iCyc < 0) iCyc = c; nPulse++; iReq = 1'b0; end
        end
        iReq = 1'b0; dReq = 1'b0;
        chk({tag, " dValid cycle"}, 64'(dCyc), 64'd2);
        chk({tag, " iValid cycle"}, 64'(iCyc), 64'd5);
        chk({tag, " pulse count"}, 64'(nPulse), 64'd2);
    endtask

    initial begin
        int  cnt;
        bit  seen, addrOk;

        vecs[0] = '{1'b0, 32'h0000_0044, 1'b0, 32'h0, 4'h0, 64'h1111_2222_3333_4444, 32'h40, 8'h00, 64'h1111_2222_3333_4444};
        vecs[1] = '{1'b1, 32'h0000_0104, 1'b1, 32'hDEAD_BEEF, 4'hF, 64'h0123_4567_89AB_CDEF, 32'h100, 8'hF0, 64'h0};
        vecs[2] = '{1'b1, 32'h0000_0100, 1'b0, 32'h0, 4'h0, 64'hAAAA_BBBB_CCCC_DDDD, 32'h100, 8'h00, 64'hCCCC_DDDD};
        vecs[3] = '{1'b1, 32'h0000_010C, 1'b0, 32'h0, 4'h0, 64'h1234_5678_9ABC_DEF0, 32'h108, 8'h00, 64'h1234_5678};
        vecs[4] = '{1'b1, 32'h0000_0208, 1'b1, 32'hCAFE_F00D, 4'h3, 64'hFFFF_FFFF_FFFF_FFFF, 32'h208, 8'h03, 64'h0};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0, 4'h0, 64'h0F0F_0F0F_A5A5_A5A5, 32'hFFFF_FFF8, 8'h00, 64'h0F0F_0F0F_A5A5_A5A5};
        vecs[6] = '{1'b1, 32'h0000_020E, 1'b1, 32'h1234_5678, 4'hC, 64'h5A5A_5A5A_5A5A_5A5A, 32'h208, 8'hC0, 64'h0};

        reset = 1'b0; iReq = 1'b0; dReq = 1'b0; dWrite = 1'b0;
        iAddress = '0; dAddress = '0; dWriteData = '0; dByteEnable = '0;
        memReady = 1'b0; memReadData = '0;
        repeat (2) @(negedge clk);
        chk("reset memRequest", 64'(memRequest), 64'd0);
        chk("reset memWrite", 64'(memWrite), 64'd0);
        chk("reset valids", 64'({iValid, dValid}), 64'd0);
        chk("reset grantData", 64'(grantData), 64'd0);
        chk("reset timeoutError", 64'(timeoutError), 64'd0);
        chk("reset memAddress", 64'(memAddress), 64'd0);
        chk("reset iData", iData, 64'd0);
        chk("reset dReadData", 64'(dReadData), 64'd0);
        reset = 1'b1;

        tieTest("tie1");

        for (int i = 0; i < 7; i++) runVec(vecs[i], i);
        chk("scoreboard empty", 64'(sb.size()), 64'd0);

        // Memory stalls five cycles before accepting the load.
        @(negedge clk);
        dReq = 1'b1; dWrite = 1'b0; dAddress = 32'h100; memReady = 1'b0;
        memReadData = 64'h5555_6666_7777_8888;
        cnt = 0; addrOk = 1'b1; seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (dValid) seen = 1'b1;
            else if (memRequest) begin
                cnt++;
                if (memAddress !== 32'h100) addrOk = 1'b0;
                if (cnt == 6) memReady = 1'b1;
            end
        end
        dReq = 1'b0;
        chk("slow issue cycles", 64'(cnt), 64'd6);
        chk("slow address stable", 64'(addrOk), 64'd1);
        chk("slow dValid", 64'(seen), 64'd1);
        chk("slow dReadData", 64'(dReadData), 64'h7777_8888);

        // Memory never answers: watchdog must abort after 255 cycles.
        @(negedge clk);
        dReq = 1'b1; dWrite = 1'b0; dAddress = 32'h200; memReady = 1'b0;
        memReadData = 64'hFFFF_FFFF_FFFF_FFFF;
        cnt = 0; seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (dValid) seen = 1'b1;
            else if (memRequest) cnt++;
        end
        dReq = 1'b0;
        chk("timeout dValid", 64'(seen), 64'd1);
        chk("timeout issue cycles", 64'(cnt), 64'd255);
        chk("timeout dReadData", 64'(dReadData), 64'd0);
        chk("timeout flag", 64'(timeoutError), 64'd1);
        runVec(vecs[2], 7);
        chk("timeout flag sticky", 64'(timeoutError), 64'd1);

        // Reset asserted while a data access is in ISSUE.
        @(negedge clk);
        dReq = 1'b1; dWrite = 1'b1; dAddress = 32'h104; dWriteData = 32'h1;
        dByteEnable = 4'hF; memReady = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-reset memRequest", 64'(memRequest), 64'd1);
        reset = 1'b0;
        #1;
        chk("async memRequest", 64'(memRequest), 64'd0);
        chk("async memWrite", 64'(memWrite), 64'd0);
        chk("async memAddress", 64'(memAddress), 64'd0);
        chk("async memByteEnable", 64'(memByteEnable), 64'd0);
        chk("async grantData", 64'(grantData), 64'd0);
        chk("async timeoutError", 64'(timeoutError), 64'd0);
        dReq = 1'b0; memReady = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (iValid || dValid) cnt++;
        end
        chk("no pulse after reset", 64'(cnt), 64'd0);
        tieTest("tie2");

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
